// File: rtl/pio_avalon_gen2.sv
// Parametrised Avalon-MM GPIO port: per-bit direction, atomic set/clear,
// synchronised inputs, armed edge capture with maskable interrupt, registered readback.
module pio_avalon_gen2 #(
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    SYNC_STAGES = 2,
  parameter int                    EDGE_TYPE   = 0,
  parameter int                    IRQ_TYPE    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic                  read_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] oe,
  output logic                  irq
);

  typedef enum logic [2:0] {
    REG_DATA        = 3'd0,
    REG_DIRECTION   = 3'd1,
    REG_IRQMASK     = 3'd2,
    REG_EDGECAPTURE = 3'd3,
    REG_OUTSET      = 3'd4,
    REG_OUTCLEAR    = 3'd5
  } reg_addr_e;

  localparam logic [2:0] ARM_COUNT = 3'(SYNC_STAGES + 1);

  logic [DATA_WIDTH-1:0] data_out;
  logic [DATA_WIDTH-1:0] direction;
  logic [DATA_WIDTH-1:0] irqmask;
  logic [DATA_WIDTH-1:0] edgecapture;
  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] sync_in;
  logic [DATA_WIDTH-1:0] sync_prev;
  logic [2:0]            arm_cnt;
  logic                  armed;

  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] ec_clr;
  logic [DATA_WIDTH-1:0] edge_hit;
  logic [DATA_WIDTH-1:0] detect;
  logic [DATA_WIDTH-1:0] rd_value;
  logic                  irq_src;

  assign wr_en   = chipselect & ~write_n;
  assign rd_en   = chipselect & ~read_n;
  assign wd      = writedata[DATA_WIDTH-1:0];
  assign sync_in = sync_q[SYNC_STAGES-1];
  assign armed   = (arm_cnt == ARM_COUNT);

  generate
    if (DATA_WIDTH < 32) begin : g_unused_wd
      logic unused_wd;
      assign unused_wd = &{1'b0, writedata[31:DATA_WIDTH]};
    end
  endgenerate

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make read-modify-write order-dependent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out  <= RESET_VALUE;
      direction <= '0;
      irqmask   <= '0;
    end else if (wr_en) begin
      case (address)
        REG_DATA:      data_out  <= wd;
        REG_DIRECTION: direction <= wd;
        REG_IRQMASK:   irqmask   <= wd;
        REG_OUTSET:    data_out  <= data_out | wd;
        REG_OUTCLEAR:  data_out  <= data_out & ~wd;
        default:       ;
      endcase
    end
  end

  // NOTE: the sync chain is an array but still gets reset, so no stale pin
  // value can be captured as an edge right after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      sync_prev <= '0;
      arm_cnt   <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sync_prev <= sync_in;
      if (!armed) arm_cnt <= arm_cnt + 3'd1;
    end
  end

  // NOTE: combinational blocks assign every output a default first so no
  // path can leave a signal unassigned and infer a latch.
  always_comb begin
    edge_hit = sync_in ^ sync_prev;
    if (EDGE_TYPE == 0)      edge_hit = sync_in & ~sync_prev;
    else if (EDGE_TYPE == 1) edge_hit = ~sync_in & sync_prev;
  end

  assign detect = armed ? edge_hit : '0;
  assign ec_clr = (wr_en && address == REG_EDGECAPTURE) ? wd : '0;

  // Detection is ORed in after the clear so a coincident set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edgecapture <= '0;
    else          edgecapture <= (edgecapture & ~ec_clr) | detect;
  end

  assign irq_src = (IRQ_TYPE == 1) ? |(edgecapture & irqmask) : |(sync_in & irqmask);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= irq_src;
  end

  always_comb begin
    rd_value = '0;
    case (address)
      REG_DATA:        rd_value = (data_out & direction) | (sync_in & ~direction);
      REG_DIRECTION:   rd_value = direction;
      REG_IRQMASK:     rd_value = irqmask;
      REG_EDGECAPTURE: rd_value = edgecapture;
      default:         rd_value = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   readdata <= '0;
    else if (rd_en) readdata <= 32'(rd_value);
  end

  assign out_port = data_out;
  assign oe       = direction;

endmodule

// File: tb/tb_pio_avalon_gen2.sv
// Self-checking bench for pio_avalon_gen2: table-driven register vectors plus
// hand-written sync, edge-capture, irq and reset sequences; reads go through a scoreboard.
module tb_pio_avalon_gen2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] in_port;
  logic [15:0] out_port;
  logic [15:0] oe;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          is_write;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [15:0] exp_out;
    logic [15:0] exp_oe;
    logic [31:0] exp_rd;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } rd_exp_t;

  vec_t    vecs[$];
  rd_exp_t sb[$];

  pio_avalon_gen2 #(
    .DATA_WIDTH (16),
    .RESET_VALUE(16'hA5A5),
    .SYNC_STAGES(2),
    .EDGE_TYPE  (0),
    .IRQ_TYPE   (1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .read_n    (read_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .out_port  (out_port),
    .oe        (oe),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // All bus tasks start at a negedge and consume exactly one rising edge.
  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    address = addr; writedata = data; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] addr, input logic [31:0] exp, input string name);
    rd_exp_t e;
    address = addr; chipselect = 1'b1; read_n = 1'b0;
    sb.push_back('{exp: exp, name: name});
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1;
    e = sb.pop_front();
    check(e.name, readdata, e.exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic vec_t mkv(input bit w, input logic [2:0] a, input logic [31:0] d,
                               input logic [15:0] eo, input logic [15:0] eoe,
                               input logic [31:0] er, input string nm);
    vec_t v;
    v.is_write = w; v.addr = a; v.wdata = d; v.exp_out = eo;
    v.exp_oe = eoe; v.exp_rd = er; v.name = nm;
    return v;
  endfunction

  initial begin
    rd_exp_t e;

    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    read_n = 1'b1; writedata = '0; in_port = '0;

    // Reset state
    idle(2);
    check("reset_out_port", 32'(out_port), 32'h0000A5A5);
    check("reset_oe", 32'(oe), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_readdata", readdata, 32'h0);
    reset_n = 1'b1;
    idle(1);
    bus_read(3'd0, 32'h0, "rd_data_after_reset");

    // Register map vectors
    vecs.push_back(mkv(1, 3'd0, 32'h000000FF, 16'h00FF, 16'h0000, 32'h0,  "data_wr"));
    vecs.push_back(mkv(1, 3'd4, 32'h00000F00, 16'h0FFF, 16'h0000, 32'h0,  "outset"));
    vecs.push_back(mkv(1, 3'd5, 32'h00000003, 16'h0FFC, 16'h0000, 32'h0,  "outclear"));
    vecs.push_back(mkv(0, 3'd4, 32'h0,        16'h0FFC, 16'h0000, 32'h0,  "rd_outset_zero"));
    vecs.push_back(mkv(0, 3'd5, 32'h0,        16'h0FFC, 16'h0000, 32'h0,  "rd_outclear_zero"));
    vecs.push_back(mkv(1, 3'd0, 32'hFFFF0000, 16'h0000, 16'h0000, 32'h0,  "data_upper_ignored"));
    vecs.push_back(mkv(1, 3'd2, 32'h00000001, 16'h0000, 16'h0000, 32'h0,  "mask_wr"));
    vecs.push_back(mkv(0, 3'd2, 32'h0,        16'h0000, 16'h0000, 32'h1,  "rd_mask"));
    vecs.push_back(mkv(1, 3'd6, 32'h0000FFFF, 16'h0000, 16'h0000, 32'h0,  "reserved_wr"));
    vecs.push_back(mkv(0, 3'd6, 32'h0,        16'h0000, 16'h0000, 32'h0,  "rd_reserved6"));
    vecs.push_back(mkv(0, 3'd7, 32'h0,        16'h0000, 16'h0000, 32'h0,  "rd_reserved7"));
    vecs.push_back(mkv(1, 3'd1, 32'h000000FF, 16'h0000, 16'h00FF, 32'h0,  "dir_wr"));
    vecs.push_back(mkv(0, 3'd1, 32'h0,        16'h0000, 16'h00FF, 32'hFF, "rd_dir"));
    vecs.push_back(mkv(1, 3'd0, 32'h00001234, 16'h1234, 16'h00FF, 32'h0,  "data_wr2"));
    vecs.push_back(mkv(0, 3'd0, 32'h0,        16'h1234, 16'h00FF, 32'h34, "rd_data_mixed"));

    foreach (vecs[i]) begin
      if (vecs[i].is_write) bus_write(vecs[i].addr, vecs[i].wdata);
      else                  bus_read(vecs[i].addr, vecs[i].exp_rd, vecs[i].name);
      check({vecs[i].name, "_out"}, 32'(out_port), 32'(vecs[i].exp_out));
      check({vecs[i].name, "_oe"},  32'(oe),       32'(vecs[i].exp_oe));
    end

    idle(2);
    check("readdata_hold", readdata, 32'h34);

    // Synchronised input readback with mixed direction
    in_port = 16'hAB00;
    idle(4);
    bus_read(3'd0, 32'h0000AB34, "rd_data_sync_in");
    bus_read(3'd3, 32'h0000AB00, "rd_ec_rises");
    check("irq_masked_off", 32'(irq), 32'h0);
    bus_write(3'd3, 32'h0000FFFF);
    bus_read(3'd3, 32'h0, "rd_ec_cleared");

    // Edge capture / irq timing on bit 0
    in_port = 16'hAB01;
    idle(3);
    check("irq_before_capture", 32'(irq), 32'h0);
    bus_read(3'd3, 32'h1, "rd_ec_bit0");
    check("irq_set", 32'(irq), 32'h1);
    bus_write(3'd3, 32'h1);
    check("irq_hold_on_clear_edge", 32'(irq), 32'h1);
    idle(1);
    check("irq_cleared", 32'(irq), 32'h0);

    // Detection coincides with a write-1-clear: set wins
    in_port = 16'hAB05;
    idle(2);
    bus_write(3'd3, 32'h4);
    bus_read(3'd3, 32'h4, "rd_ec_set_wins");
    bus_write(3'd3, 32'h4);
    bus_read(3'd3, 32'h0, "rd_ec_clear_bit2");

    // Reset mid-read with pins held high
    bus_read(3'd1, 32'hFF, "rd_dir_before_reset");
    in_port = 16'hFFFF;
    address = 3'd1; chipselect = 1'b1; read_n = 1'b0;
    sb.push_back('{exp: 32'h0, name: "rd_during_reset"});
    #2 reset_n = 1'b0;
    #1;
    e = sb.pop_front();
    check(e.name, readdata, e.exp);
    check("midreset_out_port", 32'(out_port), 32'h0000A5A5);
    check("midreset_oe", 32'(oe), 32'h0);
    check("midreset_irq", 32'(irq), 32'h0);
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    idle(6);
    bus_read(3'd3, 32'h0, "rd_no_false_capture");
    in_port = 16'hFFFE;
    idle(4);
    bus_read(3'd3, 32'h0, "rd_fall_ignored");
    in_port = 16'hFFFF;
    idle(4);
    bus_read(3'd3, 32'h1, "rd_capture_after_arm");
    check("irq_mask_reset", 32'(irq), 32'h0);
    bus_write(3'd2, 32'h1);
    check("irq_mask_lag", 32'(irq), 32'h0);
    idle(1);
    check("irq_after_mask", 32'(irq), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pio_avalon_gen2.md
Name: pio_avalon_gen2

Overview:
Parametrised Avalon-MM general-purpose I/O port. It is the next generation of the fixed 16-bit LCD data output PIO and sits on the Qsys fabric between the Nios II data master and LCD or GPIO pins. It adds:
- per-bit direction control;
- atomic bit set and bit clear;
- a synchronised input path;
- edge capture with maskable interrupt;
- registered readback.

Parameters:
DATA_WIDTH, 16, number of I/O bits (1..32).
RESET_VALUE, 0, reset value of the output data register (DATA_WIDTH bits).
SYNC_STAGES, 2, flip-flop stages on in_port (2..4).
EDGE_TYPE, 0, edge to capture: 0 = rising, 1 = falling, 2 = any.
IRQ_TYPE, 1, interrupt source: 0 = level (synced input & mask), 1 = edge (edgecapture & mask).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  3  word offset
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
read_n  in  1  active-low read strobe
writedata  in  32  write data
readdata  out  32  read data, registered, read latency 1
in_port  in  DATA_WIDTH  pad input values, asynchronous to clk
out_port  out  DATA_WIDTH  output data register
oe  out  DATA_WIDTH  per-bit output enable (= direction register)
irq  out  1  interrupt, registered, active high

Behaviour:
- Reset: reset_n is asynchronous and active-low; clock is clk. In reset:
  - data_out = RESET_VALUE; direction = 0; irqmask = 0; edgecapture = 0.
  - Sync chain = 0; sync_prev = 0; arm counter = 0.
  - readdata = 0; irq = 0.
- Write: a write occurs when chipselect && !write_n, taking effect on that rising edge. Only writedata[DATA_WIDTH-1:0] is used.
- Register map (word offsets):
  - 0 DATA: write sets data_out. Read returns, per bit, data_out when direction = 1, otherwise sync_in.
  - 1 DIRECTION: R/W, 1 = output.
  - 2 IRQMASK: R/W.
  - 3 EDGECAPTURE: read returns the capture bits. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
  - 4 OUTSET: write does data_out |= wd. Reads as 0.
  - 5 OUTCLEAR: write does data_out &= ~wd. Reads as 0.
  - 6, 7: reserved. Writes are ignored; reads return 0.
- Readdata:
  - Registered on every edge where chipselect && !read_n, and valid the following cycle (read latency 1).
  - Otherwise readdata holds its previous value.
  - Upper bits above DATA_WIDTH always read 0.
  - Reads have no side effects.
- Input sync: in_port passes through SYNC_STAGES flops; the last stage is sync_in. sync_prev is sync_in delayed 1 cycle.
- Input latency: a pin change is visible in sync_in after SYNC_STAGES edges. It is visible on readdata one read-cycle later.
- Edge detect:
  - rise = sync_in & ~sync_prev.
  - fall = ~sync_in & sync_prev.
  - Selected by EDGE_TYPE.
  - Detection applies to all bits regardless of direction.
- Arm counter: after reset release, edge detection is suppressed until SYNC_STAGES+1 edges have elapsed. This prevents false captures when pins are high at reset. The counter saturates and stays armed until the next reset.
- Edgecapture:
  - A bit is set on the edge where its edge is detected while armed.
  - The bit stays set until cleared by software.
  - If a detection and a write-1-clear hit the same bit on the same edge, the set wins and the bit stays 1.
- irq: registered, one edge after the source condition.
  - IRQ_TYPE 1: irq <= |(edgecapture & irqmask).
  - IRQ_TYPE 0: irq <= |(sync_in & irqmask).
  - Clearing edgecapture or mask deasserts irq one edge later.
- Outputs: out_port = data_out; oe = direction. Both are driven directly from registers, with no combinational path from the bus.
- Asynchronous reset mid-transaction: all state returns to its reset values immediately. A pending read returns 0.

Test Plan:
1. Reset, DATA_WIDTH=16, RESET_VALUE=16'hA5A5 -> out_port=A5A5, oe=0, irq=0. Read offset 0 with in_port=0 and direction=0 -> readdata=0.
2. Write DATA=0x00FF, OUTSET=0x0F00, OUTCLEAR=0x0003 -> out_port=0x0FFC. Read offsets 4 and 5 -> 0. Write writedata=0xFFFF0000 to DATA -> out_port=0.
3. DIRECTION=0x00FF, data_out=0x1234, in_port=0xAB00. Read DATA after SYNC_STAGES+2 cycles -> 0xAB34.
4. EDGE_TYPE=0, IRQ_TYPE=1, mask=0x0001. in_port[0] 0->1:
   - edgecapture=1 after SYNC_STAGES+1 edges;
   - irq=1 one edge later;
   - write 1 to offset 3 -> irq=0 two edges later.
5. Hold in_port=0xFFFF through reset release -> edgecapture remains 0. Then drive bit 0 low-high -> bit 0 captured.
6. Pulse in_port[2] rising so detection coincides with a write of 0x4 to offset 3 -> edgecapture[2]=1 (set wins). Assert reset_n low mid-read -> readdata=0 immediately.
